// File: rtl/input_cond_pkg.sv
// Shared types and layout helpers for the button input conditioner.
package input_cond_pkg;

   // Long-press tracker for channel 0.
   typedef enum logic [1:0] {
      LP_IDLE     = 2'd0,
      LP_COUNTING = 2'd1,
      LP_FIRED    = 2'd2
   } lp_state_t;

   // Event vector layout: presses in the low half, releases in the high half.
   localparam int PRESS_LSB = 0;

   function automatic int release_lsb(input int width);
      return width;
   endfunction

endpackage

// File: rtl/button_input_conditioner_debounce_channel.sv
// Single-bit synchroniser, counter debounce and edge pulse generator.
module debounce_channel #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic level_o,
   output logic press_o,
   output logic release_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   // Count value one short of the threshold: the next mismatch accepts the level.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             level_q;
   logic             press_q;
   logic             release_q;
   logic [CNT_W-1:0] cnt_q;

   // Two-flop synchroniser, then count consecutive cycles disagreeing with the level.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         sync1_q   <= btn_i;
         sync2_q   <= sync1_q;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         if (sync2_q == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            level_q   <= ~level_q;
            press_q   <= ~level_q;
            release_q <= level_q;
            cnt_q     <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;

endmodule

// File: rtl/button_input_conditioner.sv
// Push-button conditioner: debounced levels, edge pulses, sticky events with
// read-and-clear, level IRQ and a long-press reset request on channel 0.
module button_input_conditioner
   import input_cond_pkg::*;
#(
   parameter int WIDTH             = 5,
   parameter int DEBOUNCE_CYCLES   = 500000,
   parameter int LONG_PRESS_CYCLES = 100000000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   btn_i,
   output logic [WIDTH-1:0]   level_o,
   output logic [WIDTH-1:0]   press_o,
   output logic [WIDTH-1:0]   release_o,
   input  logic               evt_rd_i,
   output logic               evt_rvalid_o,
   output logic [2*WIDTH-1:0] evt_rdata_o,
   output logic               irq_o,
   output logic               rst_req_o
);

   localparam int LP_W = $clog2(LONG_PRESS_CYCLES + 1);
   localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CYCLES - 1);
   localparam int REL_LSB = release_lsb(WIDTH);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_chan
         debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .btn_i    (btn_i[gi]),
            .level_o  (level_o[gi]),
            .press_o  (press_o[gi]),
            .release_o(release_o[gi])
         );
      end
   endgenerate

   logic [2*WIDTH-1:0] set_vec;
   logic [2*WIDTH-1:0] pend_q, pend_d;
   logic               rvalid_q;
   logic [2*WIDTH-1:0] rdata_q;
   logic               irq_q;

   // Pending update: clear what the read snapshots, then set new pulses (set wins).
   always_comb begin
      set_vec = '0;
      set_vec[PRESS_LSB +: WIDTH] = press_o;
      set_vec[REL_LSB +: WIDTH]   = release_o;
      pend_d = (evt_rd_i ? '0 : pend_q) | set_vec;
   end

   // Event register, read response and IRQ; irq tracks pend with no extra lag.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q   <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         irq_q    <= 1'b0;
      end else begin
         pend_q   <= pend_d;
         rvalid_q <= evt_rd_i;
         rdata_q  <= evt_rd_i ? pend_q : '0;
         irq_q    <= |pend_d;
      end
   end

   lp_state_t       state_q, state_d;
   logic [LP_W-1:0] lp_cnt_q, lp_cnt_d;
   logic            rst_req_q, rst_req_d;

   // Long-press next state: fire once when the hold count reaches its last value.
   always_comb begin
      state_d   = state_q;
      lp_cnt_d  = lp_cnt_q;
      rst_req_d = 1'b0;
      case (state_q)
         LP_IDLE: begin
            if (press_o[0]) begin
               state_d  = LP_COUNTING;
               lp_cnt_d = '0;
            end
         end
         LP_COUNTING: begin
            if (!level_o[0]) begin
               state_d = LP_IDLE;
            end else if (lp_cnt_q != LP_LAST) begin
               lp_cnt_d = lp_cnt_q + LP_W'(1);
            end
         end
         LP_FIRED: begin
            if (release_o[0]) begin
               state_d = LP_IDLE;
            end
         end
         default: state_d = LP_IDLE;
      endcase
      if (state_d == LP_COUNTING && lp_cnt_d == LP_LAST) begin
         rst_req_d = 1'b1;
         state_d   = LP_FIRED;
      end
   end

   // Long-press state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= LP_IDLE;
         lp_cnt_q  <= '0;
         rst_req_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         lp_cnt_q  <= lp_cnt_d;
         rst_req_q <= rst_req_d;
      end
   end

   assign evt_rvalid_o = rvalid_q;
   assign evt_rdata_o  = rdata_q;
   assign irq_o        = irq_q;
   assign rst_req_o    = rst_req_q;

endmodule

// File: tb/tb_button_input_conditioner.sv
// Directed bench for button_input_conditioner (WIDTH=5, debounce 4, long press 8).
module tb_button_input_conditioner;

   localparam int W = 5;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [W-1:0]   btn_i = '0;
   logic [W-1:0]   level_o, press_o, release_o;
   logic           evt_rd_i = 1'b0;
   logic           evt_rvalid_o;
   logic [2*W-1:0] evt_rdata_o;
   logic           irq_o;
   logic           rst_req_o;

   int checks = 0;
   int errors = 0;

   button_input_conditioner #(
      .WIDTH(W),
      .DEBOUNCE_CYCLES(4),
      .LONG_PRESS_CYCLES(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_i(btn_i),
      .level_o(level_o),
      .press_o(press_o),
      .release_o(release_o),
      .evt_rd_i(evt_rd_i),
      .evt_rvalid_o(evt_rvalid_o),
      .evt_rdata_o(evt_rdata_o),
      .irq_o(irq_o),
      .rst_req_o(rst_req_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   // Advance one clock; inputs driven and outputs sampled 1 ns after the edge.
   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic read_evt(input string tag, input logic [31:0] exp);
      evt_rd_i = 1'b1;
      tick();
      evt_rd_i = 1'b0;
      chk({tag, "_rvalid"}, 32'(evt_rvalid_o), 32'd1);
      chk({tag, "_rdata"}, 32'(evt_rdata_o), exp);
   endtask

   initial begin
      // Reset state
      tick(3);
      chk("rst_level", 32'(level_o), 0);
      chk("rst_press", 32'(press_o), 0);
      chk("rst_irq", 32'(irq_o), 0);
      chk("rst_rvalid", 32'(evt_rvalid_o), 0);
      chk("rst_rdata", 32'(evt_rdata_o), 0);
      chk("rst_req", 32'(rst_req_o), 0);
      rst = 1'b0;
      tick(2);

      // 1. Clean press on ch2: visible on the 6th edge after the pin change
      btn_i[2] = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (i < 6) chk($sformatf("t1_press_c%0d", i), 32'(press_o), 0);
      end
      chk("t1_press", 32'(press_o), 32'h04);
      chk("t1_level", 32'(level_o), 32'h04);
      chk("t1_irq_early", 32'(irq_o), 0);
      tick();
      chk("t1_press_gone", 32'(press_o), 0);
      chk("t1_irq", 32'(irq_o), 1);
      read_evt("t1_rd", 32'h004);
      chk("t1_irq_clr", 32'(irq_o), 0);
      tick();
      chk("t1_rvalid_off", 32'(evt_rvalid_o), 0);
      chk("t1_rdata_off", 32'(evt_rdata_o), 0);
      btn_i[2] = 1'b0;
      tick(10);
      read_evt("t1_rd_rel", 32'h080);
      tick();

      // 2. Glitch of 3 cycles on ch1 is ignored
      btn_i[1] = 1'b1;
      tick(3);
      btn_i[1] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("t2_glitch_press%0d", i), 32'(press_o | level_o), 0);
      end
      chk("t2_glitch_irq", 32'(irq_o), 0);
      // 5-cycle pulse: press on the 6th edge, release 5 edges later
      btn_i[1] = 1'b1;
      tick(5);
      btn_i[1] = 1'b0;
      tick();
      chk("t2_press", 32'(press_o), 32'h02);
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk($sformatf("t2_release%0d", i), 32'(release_o), (i == 5) ? 32'h02 : 32'h00);
      end
      tick();
      read_evt("t2_rd", 32'h042);
      tick();

      // 3. Read in the same cycle as a new press: snapshot excludes it
      btn_i[3] = 1'b1;
      tick(6);
      chk("t3_press3", 32'(press_o), 32'h08);
      btn_i[4] = 1'b1;
      tick(6);
      chk("t3_press4", 32'(press_o), 32'h10);
      read_evt("t3_rd1", 32'h008);
      chk("t3_irq_hold", 32'(irq_o), 1);
      tick();
      read_evt("t3_rd2", 32'h010);
      chk("t3_irq_drop", 32'(irq_o), 0);
      btn_i = '0;
      tick(10);
      read_evt("t3_rd_rel", 32'h300);
      tick();

      // 4. Long press on ch0: one pulse 8 cycles after press, per hold
      for (int rep = 0; rep < 2; rep++) begin
         btn_i[0] = 1'b1;
         tick(6);
         chk($sformatf("t4_press_r%0d", rep), 32'(press_o), 32'h01);
         for (int k = 1; k <= 20; k++) begin
            tick();
            chk($sformatf("t4_req_r%0d_k%0d", rep, k), 32'(rst_req_o), (k == 8) ? 32'd1 : 32'd0);
         end
         btn_i[0] = 1'b0;
         tick(10);
      end
      btn_i[0] = 1'b1;
      tick(6);
      chk("t4_short_press", 32'(press_o), 32'h01);
      btn_i[0] = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         tick();
         chk($sformatf("t4_short_k%0d", k), 32'(rst_req_o), 0);
      end
      read_evt("t4_rd", 32'h021);
      tick();

      // 5. All channels at once
      btn_i = 5'b11111;
      tick(6);
      chk("t5_press_all", 32'(press_o), 32'h1F);
      tick();
      read_evt("t5_rd", 32'h01F);
      btn_i = '0;
      tick(10);
      read_evt("t5_rd_rel", 32'h3E0);
      tick();

      // 6. Reset mid-debounce on ch2 with the button held
      btn_i[2] = 1'b1;
      tick(2);
      rst = 1'b1;
      tick();
      chk("t6_rst_level", 32'(level_o), 0);
      chk("t6_rst_press", 32'(press_o), 0);
      chk("t6_rst_irq", 32'(irq_o), 0);
      chk("t6_rst_req", 32'(rst_req_o), 0);
      tick();
      rst = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         chk($sformatf("t6_press_c%0d", i), 32'(press_o), (i == 6) ? 32'h04 : 32'h00);
      end
      tick();
      chk("t6_irq", 32'(irq_o), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
